// File: rtl/clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_ctrl_pkg
//   Shared types and constants for the CPU clock step controller.
//   - Mode encodings as driven by the board switches.
//   - mode_t: typed view of the two Mode switch bits.
//   - state_t: run/step controller states.
// ---------------------------------------------------------------------------
package clk_ctrl_pkg;

    localparam logic [1:0] MODE_ENC_RUN   = 2'b00;
    localparam logic [1:0] MODE_ENC_PAUSE = 2'b01;
    localparam logic [1:0] MODE_ENC_STEP  = 2'b10;
    localparam logic [1:0] MODE_ENC_RSVD  = 2'b11;  // behaves as PAUSE

    typedef enum logic [1:0] {
        MODE_RUN   = MODE_ENC_RUN,
        MODE_PAUSE = MODE_ENC_PAUSE,
        MODE_STEP  = MODE_ENC_STEP,
        MODE_RSVD  = MODE_ENC_RSVD
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_STEP_LO = 2'b10,
        S_STEP_HI = 2'b11
    } state_t;

endpackage

// File: rtl/step_debouncer.sv
// ---------------------------------------------------------------------------
// step_debouncer
//   Cleans up the raw single-step push-button.
//   - Two-flop synchroniser brings the asynchronous button into CLOCK.
//   - The accepted level only changes after DEBOUNCE consecutive synchronised
//     samples that all disagree with the current level.
//   - rise_pulse is a one-CLOCK registered pulse, high in the cycle right
//     after the accepted level went 0 -> 1.
// Ports
//   CLOCK      in   rising-edge clock
//   Reset      in   asynchronous reset, active-low
//   raw_in     in   raw, asynchronous button (active-high)
//   level_out  out  debounced button level
//   rise_pulse out  one-cycle pulse on a debounced rising edge
// ---------------------------------------------------------------------------
module step_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic CLOCK,
    input  logic Reset,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= raw_in;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            // stable_cnt counts how many samples in a row disagreed with the
            // accepted level; any agreeing sample restarts the run.
            if (sync2 == level_out) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE - 1)) begin
                level_out  <= sync2;
                rise_pulse <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_step_ctrl.sv
// ---------------------------------------------------------------------------
// clock_step_ctrl
//   Derives the CPU clock ClockDIV from the memory clock CLOCK with a
//   programmable half-period, and adds free-run, pause and single-step modes.
//   - Each ClockDIV phase lasts HALF_DIV CLOCK cycles; a period is 2*HALF_DIV.
//   - RUN only stops at the end of a high phase, so periods never get cut.
//   - A single step is one full high/low/high sequence: one CpuTick per press.
//   - CpuTick and the CycleCount increment share the edge that raises ClockDIV.
// Ports
//   CLOCK      in   memory clock, all state on its rising edge
//   Reset      in   asynchronous reset, active-low
//   Mode       in   00=RUN, 01=PAUSE, 10=STEP, 11=PAUSE
//   StepBtn    in   raw single-step button, active-high
//   ClockDIV   out  registered CPU clock (1 while idle)
//   CpuTick    out  one-CLOCK pulse when ClockDIV has just risen
//   CycleCount out  ClockDIV rising edges since reset, wraps silently
//   Running    out  1 while the controller is in S_RUN
//   DebugInfo  out  {debounced StepBtn level, FSM state} for observation
// ---------------------------------------------------------------------------
module clock_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int HALF_DIV = 1,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 32
) (
    input  logic             CLOCK,
    input  logic             Reset,
    input  logic [1:0]       Mode,
    input  logic             StepBtn,
    output logic             ClockDIV,
    output logic             CpuTick,
    output logic [CNT_W-1:0] CycleCount,
    output logic             Running,
    output logic [2:0]       DebugInfo
);

    localparam int PH_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            clk_d;
    logic            tick_d;
    logic            cnt_en;
    logic            terminal;
    mode_t           mode;
    logic            step_level;
    logic            step_rise;

    step_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_step_debouncer (
        .CLOCK      (CLOCK),
        .Reset      (Reset),
        .raw_in     (StepBtn),
        .level_out  (step_level),
        .rise_pulse (step_rise)
    );

    assign mode     = mode_t'(Mode);
    assign terminal = (phase_q == PH_LAST);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        clk_d   = ClockDIV;
        tick_d  = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Entering RUN or STEP_LO starts a fresh high phase, so
                // ClockDIV first falls HALF_DIV cycles later.
                clk_d   = 1'b1;
                phase_d = '0;
                if (mode == MODE_RUN) begin
                    state_d = S_RUN;
                end else if (mode == MODE_STEP && step_rise) begin
                    state_d = S_STEP_LO;
                end
            end
            S_RUN, S_STEP_LO: begin
                if (terminal) begin
                    phase_d = '0;
                    if (ClockDIV) begin
                        // End of a high phase: the only point RUN may stop.
                        if (state_q == S_RUN && mode != MODE_RUN) begin
                            state_d = S_IDLE;
                        end else begin
                            clk_d = 1'b0;
                        end
                    end else begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                        cnt_en = 1'b1;
                        if (state_q == S_STEP_LO) begin
                            state_d = S_STEP_HI;
                        end
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_STEP_HI: begin
                if (terminal) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                clk_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            ClockDIV   <= 1'b1;
            CpuTick    <= 1'b0;
            CycleCount <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ClockDIV <= clk_d;
            CpuTick  <= tick_d;
            if (cnt_en) begin
                CycleCount <= CycleCount + CNT_W'(1);
            end
        end
    end

    assign Running   = (state_q == S_RUN);
    assign DebugInfo = {step_level, state_q};

endmodule

// File: tb/tb_clock_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_step_ctrl
//   Three controllers with different HALF_DIV / DEBOUNCE / CNT_W share one
//   stimulus stream. A phase-plan model predicts each one: whenever a
//   decision point is reached it queues the ClockDIV/CpuTick values for the
//   coming cycles, and the debounced button is derived from a history of
//   synchronised samples.
// ---------------------------------------------------------------------------
module tb_clock_step_ctrl;

    logic       CLOCK;
    logic       Reset;
    logic [1:0] Mode;
    logic       StepBtn;

    logic       cd0, cd1, cd2;
    logic       ct0, ct1, ct2;
    logic       rn0, rn1, rn2;
    logic [3:0] cc0;
    logic [5:0] cc1;
    logic [3:0] cc2;
    logic [2:0] dbg0, dbg1, dbg2;

    logic        cd [3];
    logic        ct [3];
    logic        rn [3];
    logic [31:0] cc [3];

    assign cd[0] = cd0; assign cd[1] = cd1; assign cd[2] = cd2;
    assign ct[0] = ct0; assign ct[1] = ct1; assign ct[2] = ct2;
    assign rn[0] = rn0; assign rn[1] = rn1; assign rn[2] = rn2;
    assign cc[0] = 32'(cc0); assign cc[1] = 32'(cc1); assign cc[2] = 32'(cc2);

    clock_step_ctrl #(.HALF_DIV(1), .DEBOUNCE(4), .CNT_W(4)) u_dut0 (
        .CLOCK(CLOCK), .Reset(Reset), .Mode(Mode), .StepBtn(StepBtn),
        .ClockDIV(cd0), .CpuTick(ct0), .CycleCount(cc0), .Running(rn0),
        .DebugInfo(dbg0));

    clock_step_ctrl #(.HALF_DIV(3), .DEBOUNCE(3), .CNT_W(6)) u_dut1 (
        .CLOCK(CLOCK), .Reset(Reset), .Mode(Mode), .StepBtn(StepBtn),
        .ClockDIV(cd1), .CpuTick(ct1), .CycleCount(cc1), .Running(rn1),
        .DebugInfo(dbg1));

    clock_step_ctrl #(.HALF_DIV(2), .DEBOUNCE(4), .CNT_W(4)) u_dut2 (
        .CLOCK(CLOCK), .Reset(Reset), .Mode(Mode), .StepBtn(StepBtn),
        .ClockDIV(cd2), .CpuTick(ct2), .CycleCount(cc2), .Running(rn2),
        .DebugInfo(dbg2));

    // ---------------- clock ----------------
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // ---------------- scoreboard / model state ----------------
    int n_vec = 0;
    int n_err = 0;

    localparam int K_IDLE = 0;
    localparam int K_RUN  = 1;
    localparam int K_STEP = 2;

    logic [1:0] exp_q [3][$];    // planned {ClockDIV, CpuTick} per coming cycle
    int         kind  [3];
    int         e_cnt [3];
    bit         e_cd  [3];
    bit         e_ct  [3];
    bit         e_run [3];
    bit         level [3];
    bit         rise  [3];
    bit         raw_q [$];       // button samples still inside the synchroniser
    bit         seen_h[$];       // synchronised samples since reset

    function automatic int hd_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int db_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 3 : 4;
    endfunction

    function automatic int w_of(input int i);
        return (i == 1) ? 6 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        raw_q.delete();
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
        seen_h.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            kind[i]  = K_IDLE;
            e_cnt[i] = 0;
            e_cd[i]  = 1'b1;
            e_ct[i]  = 1'b0;
            e_run[i] = 1'b0;
            level[i] = 1'b0;
            rise[i]  = 1'b0;
        end
    endtask

    task automatic push_n(input int i, input int n, input logic [1:0] v);
        for (int k = 0; k < n; k++) exp_q[i].push_back(v);
    endtask

    // One rising CLOCK edge of the model, using the inputs present at it.
    task automatic model_edge();
        bit s;
        bit stable;
        logic [1:0] e;
        int h;
        if (!Reset) begin
            model_reset();
            return;
        end
        raw_q.push_back(StepBtn);
        s = raw_q.pop_front();
        seen_h.push_back(s);
        if (seen_h.size() > 8) void'(seen_h.pop_front());
        for (int i = 0; i < 3; i++) begin
            h = hd_of(i);
            e_ct[i] = 1'b0;
            if (exp_q[i].size() > 0) begin
                e = exp_q[i].pop_front();
                e_cd[i] = e[1];
                e_ct[i] = e[0];
            end else if (kind[i] == K_IDLE) begin
                e_cd[i] = 1'b1;
                if (Mode == 2'b00) begin
                    kind[i] = K_RUN;
                    push_n(i, h - 1, 2'b10);
                end else if (Mode == 2'b10 && rise[i]) begin
                    kind[i] = K_STEP;
                    push_n(i, h - 1, 2'b10);
                    push_n(i, h, 2'b00);
                    push_n(i, 1, 2'b11);
                    push_n(i, h - 1, 2'b10);
                end
            end else if (kind[i] == K_RUN && Mode == 2'b00) begin
                e_cd[i] = 1'b0;
                push_n(i, h - 1, 2'b00);
                push_n(i, 1, 2'b11);
                push_n(i, h - 1, 2'b10);
            end else begin
                e_cd[i] = 1'b1;
                kind[i] = K_IDLE;
            end
            if (e_ct[i]) e_cnt[i] = (e_cnt[i] + 1) % (1 << w_of(i));
            e_run[i] = (kind[i] == K_RUN);

            // debounced level: last DEBOUNCE samples agree and differ from it
            rise[i] = 1'b0;
            if (seen_h.size() >= db_of(i) && s != level[i]) begin
                stable = 1'b1;
                for (int k = 0; k < db_of(i); k++)
                    if (seen_h[seen_h.size() - 1 - k] != s) stable = 1'b0;
                if (stable) begin
                    level[i] = s;
                    rise[i]  = s;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.u%0d.ClockDIV", tag, i), 32'(cd[i]), 32'(e_cd[i]));
            check($sformatf("%s.u%0d.CpuTick", tag, i), 32'(ct[i]), 32'(e_ct[i]));
            check($sformatf("%s.u%0d.CycleCount", tag, i), cc[i], 32'(e_cnt[i]));
            check($sformatf("%s.u%0d.Running", tag, i), 32'(rn[i]), 32'(e_run[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    string phase_tag = "init";

    task automatic tick_cycle();
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
        compare_all(phase_tag);
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) tick_cycle();
    endtask

    task automatic wait_low(input int i, input int budget);
        int n;
        n = 0;
        while (cd[i] !== 1'b0 && n < budget) begin
            tick_cycle();
            n++;
        end
        check($sformatf("%s.u%0d.wait_low", phase_tag, i), 32'(cd[i] === 1'b0), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold;
        Reset   = 1'b0;
        Mode    = 2'b01;
        StepBtn = 1'b0;
        model_reset();

        phase_tag = "reset";
        run_cycles(3);
        Reset = 1'b1;

        phase_tag = "run";
        Mode = 2'b00;
        run_cycles(60);

        // pause requested while the HALF_DIV=3 clock is low
        phase_tag = "pause";
        wait_low(1, 20);
        Mode = 2'b01;
        run_cycles(30);

        // step: short glitch, then a proper press
        phase_tag = "glitch";
        Mode = 2'b10;
        run_cycles(5);
        StepBtn = 1'b1;
        run_cycles(2);
        StepBtn = 1'b0;
        run_cycles(20);
        phase_tag = "step";
        StepBtn = 1'b1;
        run_cycles(10);
        StepBtn = 1'b0;
        run_cycles(30);

        // second press arriving while a step is still in progress
        phase_tag = "step2";
        StepBtn = 1'b1;
        run_cycles(7);
        StepBtn = 1'b0;
        run_cycles(5);
        StepBtn = 1'b1;
        run_cycles(6);
        StepBtn = 1'b0;
        run_cycles(40);

        // long run: the 4-bit counters wrap
        phase_tag = "wrap";
        Mode = 2'b00;
        run_cycles(80);
        Mode = 2'b11;
        run_cycles(20);

        // asynchronous reset in the middle of a step low phase
        phase_tag = "arst";
        Mode = 2'b10;
        StepBtn = 1'b1;
        wait_low(2, 40);
        Reset = 1'b0;
        #1;
        model_reset();
        compare_all("arst_now");
        Mode = 2'b00;
        StepBtn = 1'b0;
        run_cycles(2);
        Reset = 1'b1;
        phase_tag = "resume";
        run_cycles(40);

        // randomized modes and button activity
        phase_tag = "rand";
        hold = 1;
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 39) == 0) Mode = 2'($urandom_range(0, 3));
            hold--;
            if (hold == 0) begin
                StepBtn = ~StepBtn;
                hold = $urandom_range(1, 12);
            end
            tick_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
